// File: rtl/sr_lock_arbiter.sv
// Round-robin lock arbiter: grants one of N requesters exclusive ownership of a
// shared flag, releases on owner rel or on a hold watchdog, then idles one dead cycle.
module sr_lock_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 255,
  parameter int HOLD_W   = 8,
  localparam int PW      = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      rel,
  output logic [N-1:0]      gnt,
  output logic              busy,
  output logic [PW-1:0]     owner,
  output logic              timeout,
  output logic [HOLD_W-1:0] hold_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: req is a level held until granted; a grant lasts until the owner
  // raises its own rel bit (sampled on the edge) or the watchdog expires.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    GAP    = 2'd2
  } state_t;

  localparam logic              WD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] WD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  state_t              state_q, state_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                timeout_q, timeout_d;

  logic [PW:0]         scan_idx;
  logic                win_found;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       win_next;
  logic                rel_own;
  logic                wd_fire;

  // Rotating scan starting at ptr; first requester found wins.
  always_comb begin
    scan_idx  = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = {1'b0, ptr_q} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(N)) scan_idx = scan_idx - (PW+1)'(N);
      if (!win_found && req[scan_idx[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    win_next = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
    rel_own  = rel[owner_q];
    wd_fire  = WD_EN && (hold_q == WD_LAST) && !rel_own;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = LOCKED;
      LOCKED:  if (rel_own || wd_fire) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Release beats the watchdog when both land in the same cycle.
  always_comb begin
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        hold_d = '0;
        if (win_found) begin
          gnt_d   = N'(1) << win_idx;
          owner_d = win_idx;
          ptr_d   = win_next;
        end
      end
      LOCKED: begin
        if (rel_own) begin
          gnt_d  = '0;
          hold_d = '0;
        end else if (wd_fire) begin
          gnt_d     = '0;
          hold_d    = '0;
          timeout_d = 1'b1;
        end else if (hold_q != '1) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      GAP: begin
        gnt_d  = '0;
        hold_d = '0;
      end
      default: begin
        gnt_d  = '0;
        hold_d = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign busy      = |gnt_q;
  assign owner     = owner_q;
  assign timeout   = timeout_q;
  assign hold_cnt  = hold_q;
  assign dbg_state = state_q;

  a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_timeout_free: assert property (@(posedge clk) disable iff (rst) timeout_q |-> (gnt_q == '0));

endmodule
